// File: rtl/beat_burst_pkg.sv
// Shared types and constants for the beat burst generator.
//   state_e     : burst FSM state (GAP is only reachable with BEAT_BURST_GAP_EN)
//   MAX_VAL_DEF : default clamp value for the requested burst length
package beat_burst_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        GAP  = 2'd2
    } state_e;

    localparam int unsigned MAX_VAL_DEF = 128;

endpackage

// File: rtl/burst_down_counter.sv
// Loadable down counter with zero/one flags.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   load_i       : load load_val_i (has priority over dec_i)
//   dec_i        : decrement by one, saturating at zero
//   cnt_o        : current count
//   zero_o/one_o : count equals 0 / 1
module burst_down_counter
    import beat_burst_pkg::*;
#(
    parameter int unsigned WIDTH_P = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               load_i,
    input  logic [WIDTH_P-1:0] load_val_i,
    input  logic               dec_i,
    output logic [WIDTH_P-1:0] cnt_o,
    output logic               zero_o,
    output logic               one_o
);

    logic [WIDTH_P-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - WIDTH_P'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);
    assign one_o  = (cnt_q == WIDTH_P'(1));

endmodule

// File: rtl/beat_burst_gen.sv
// Turns a requested beat count into that many valid/ready beats, each tagged with
// its index and a last flag.
//   clk_i, rst_i      : clock, asynchronous active-high reset
//   count_i, valid_i  : burst request; ready_o high while a request can be taken
//   valid_o, ready_i  : beat handshake; idx_o = beat index, last_o = final beat
//   done_o            : one-cycle pulse after a burst completes normally
//   busy_o            : burst in progress
//   abort_i           : cancel current burst (ignored in IDLE)
//   gap_i             : idle cycles between beats (only with BEAT_BURST_GAP_EN)
// Optional feature macro: BEAT_BURST_GAP_EN
module beat_burst_gen
    import beat_burst_pkg::*;
#(
    parameter int unsigned WIDTH_P   = 32,
    parameter int unsigned MAX_VAL_P = MAX_VAL_DEF
`ifdef BEAT_BURST_GAP_EN
    ,
    parameter int unsigned GAP_W_P   = 8
`endif
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [WIDTH_P-1:0] count_i,
    input  logic               valid_i,
    output logic               ready_o,
    output logic               valid_o,
    input  logic               ready_i,
    output logic [WIDTH_P-1:0] idx_o,
    output logic               last_o,
    output logic               done_o,
    output logic               busy_o,
    input  logic               abort_i
`ifdef BEAT_BURST_GAP_EN
    ,
    input  logic [GAP_W_P-1:0] gap_i
`endif
);

    localparam logic [WIDTH_P-1:0] MaxVal = WIDTH_P'(MAX_VAL_P);

    state_e             state_q, state_d;
    logic               done_q, done_d;
    logic [WIDTH_P-1:0] idx_q, idx_d;
    logic [WIDTH_P-1:0] count_clamped;
    logic               accept;
    logic               hs;
    logic [WIDTH_P-1:0] rem_cnt;
    logic               rem_zero;
    logic               rem_one;

    assign count_clamped = (count_i > MaxVal) ? MaxVal : count_i;
    assign accept        = (state_q == IDLE) && valid_i;
    assign hs            = (state_q == RUN) && ready_i;

    burst_down_counter #(
        .WIDTH_P (WIDTH_P)
    ) u_rem (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (accept),
        .load_val_i (count_clamped),
        .dec_i      (hs),
        .cnt_o      (rem_cnt),
        .zero_o     (rem_zero),
        .one_o      (rem_one)
    );

    logic unused_rem;
    assign unused_rem = ^{rem_cnt, rem_zero};

`ifdef BEAT_BURST_GAP_EN
    logic [GAP_W_P-1:0] gap_q;
    logic               gap_load;
    logic [GAP_W_P-1:0] gap_cnt;
    logic               gap_zero;
    logic               gap_one;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            gap_q <= '0;
        end else if (accept) begin
            gap_q <= gap_i;
        end
    end

    burst_down_counter #(
        .WIDTH_P (GAP_W_P)
    ) u_gap (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (gap_load),
        .load_val_i (gap_q),
        .dec_i      (state_q == GAP),
        .cnt_o      (gap_cnt),
        .zero_o     (gap_zero),
        .one_o      (gap_one)
    );

    logic unused_gap;
    assign unused_gap = ^{gap_cnt, gap_zero};
`endif

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
`ifdef BEAT_BURST_GAP_EN
        gap_load = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (valid_i) begin
                    // A zero-length request completes without emitting beats.
                    if (count_clamped == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                // Abort wins over the handshake; a beat taken this cycle still counts.
                if (abort_i) begin
                    state_d = IDLE;
                end else if (ready_i) begin
                    if (rem_one) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
`ifdef BEAT_BURST_GAP_EN
                    end else if (gap_q != '0) begin
                        state_d  = GAP;
                        gap_load = 1'b1;
`endif
                    end
                end
            end
`ifdef BEAT_BURST_GAP_EN
            GAP: begin
                if (abort_i) begin
                    state_d = IDLE;
                end else if (gap_one) begin
                    state_d = RUN;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        idx_d = idx_q;
        if (accept) begin
            idx_d = '0;
        end else if (hs) begin
            idx_d = idx_q + WIDTH_P'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            idx_q   <= idx_d;
        end
    end

    assign ready_o = (state_q == IDLE);
    assign valid_o = (state_q == RUN);
    assign busy_o  = (state_q != IDLE);
    assign last_o  = (state_q == RUN) && rem_one;
    assign idx_o   = idx_q;
    assign done_o  = done_q;

endmodule
